// File: rtl/serial_receiver_parity_if.sv
// rtl/serial_receiver_parity_if.sv - serial line in, recovered byte and strobe out
interface serial_receiver_parity_if;
    logic       i_data;
    logic [7:0] out_byte;
    logic       done;

    modport master (
        output i_data,
        input  out_byte,
        input  done
    );

    modport slave (
        input  i_data,
        output out_byte,
        output done
    );
endinterface

// File: rtl/serial_receiver_parity.sv
// rtl/serial_receiver_parity.sv - one-bit-per-clock 8O1 frame receiver
module serial_receiver_parity (
    input  logic                          clk,
    input  logic                          rst,
    serial_receiver_parity_if.slave       bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       par_q, par_d;
    logic [7:0] byte_q, byte_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.i_data) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                    par_d   = 1'b0;
                end
            end
            ST_DATA: begin
                byte_d  = {bus.i_data, byte_q[7:1]};
                par_d   = par_q ^ bus.i_data;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                par_d   = par_q ^ bus.i_data;
                state_d = ST_STOP;
            end
            ST_STOP: begin
                if (!bus.i_data) begin
                    state_d = ST_ERR;
                end else if (par_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                // A low line here is already the next frame's start bit.
                if (!bus.i_data) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                    par_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (bus.i_data) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            par_q   <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            byte_q  <= byte_d;
        end
    end

    assign bus.out_byte = byte_q;
    assign bus.done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_receiver_parity.sv
// tb/tb_serial_receiver_parity.sv - scoreboard bench for serial_receiver_parity
module tb_serial_receiver_parity;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [7:0] b;
        int         c;
    } exp_t;

    exp_t exp_q[$];

    serial_receiver_parity_if bus ();

    serial_receiver_parity dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pop the scoreboard whenever the DUT strobes done.
    logic prev_done;
    initial prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst && bus.done === 1'b1) begin
            check("done_single_cycle", int'(prev_done), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_byte", int'(bus.out_byte), int'(e.b));
                check("done_cycle", cyc, e.c);
            end
        end
        prev_done = (bus.done === 1'b1);
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.i_data = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic p, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(p);
        send_bit(stop);
        if (stop && ((^data) ^ p)) begin
            exp_t e;
            e.b = data;
            e.c = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.i_data = 1'b1;
        #2;
        check("reset_done", int'(bus.done), 0);
        check("reset_out_byte", int'(bus.out_byte), 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(8);

        send_frame(8'h55, 1'b1, 1'b1);
        idle(3);
        send_frame(8'hAA, 1'b1, 1'b1);
        idle(3);

        // Parity error leaves the byte visible without a strobe.
        send_frame(8'h01, 1'b1, 1'b1);
        idle(3);
        check("parity_err_out_byte", int'(bus.out_byte), 8'h01);
        send_frame(8'h55, 1'b1, 1'b1);
        idle(3);

        send_frame(8'h55, 1'b1, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        idle(2);
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(3);

        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b1);
        idle(4);

        // Asynchronous reset in the middle of a cycle while idle.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_done", int'(bus.done), 0);
        check("async_rst_out_byte", int'(bus.out_byte), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // Reset mid-frame aborts it.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("midframe_rst_out_byte", int'(bus.out_byte), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        bus.i_data = 1'b1;
        idle(4);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(5);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/serial_receiver_parity.md
# serial_receiver_parity

Serial receiver recovering 8-bit bytes from a one-bit-per-clock serial line. Each frame is a start bit, 8 data bits LSB first, an odd-parity bit and a stop bit. `done` is asserted only for frames with a correct stop bit and correct odd parity. The block sits behind the line input as a simple byte front-end; there is no oversampling, and each bit occupies exactly one clock.

## Interface
- No parameters. Frame format is fixed: 8 data bits, odd parity, 1 stop bit.
- `clk` input 1: single clock; all sampling on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `i_data` input 1: serial line; idles high; one bit per clock.
- `out_byte` output 8: assembled data byte; bit 0 is the first data bit received.
- `done` output 1: one-cycle valid strobe for a good frame.

## Operation
- States: IDLE, DATA, PARITY, STOP, DONE, ERR. A 3-bit counter tracks data bits.
- IDLE: on `i_data`=0 (start bit), go to DATA and clear the counter. Otherwise stay in IDLE.
- DATA: shift `i_data` into the byte LSB-first (new bit enters at bit 7, register shifts right), so bit 0 is received first. Increment the counter; after the 8th bit, go to PARITY.
- PARITY: sample `i_data` as the parity bit and go to STOP. Parity is good when data bits plus parity bit contain an odd number of 1s.
  - Track with a running XOR that is cleared at the start bit and XORed with each data bit and the parity bit.
  - Good parity means the final XOR = 1.
- STOP:
  - `i_data`=1 and parity good: go to DONE.
  - `i_data`=1 and parity bad: go to IDLE; no `done`.
  - `i_data`=0 (framing error): go to ERR.
- DONE: `done`=1.
  - `i_data`=0 in this cycle is a new start bit: go to DATA with the counter and parity cleared (back-to-back frames).
  - Otherwise go to IDLE.
- ERR: wait for `i_data`=1, then go to IDLE. A 0 in ERR is never treated as a start bit.
- `out_byte` is a register holding the most recently shifted data. It is updated only in DATA and holds its value in every other state.
  - It equals the frame's byte while `done`=1.
  - After a frame rejected for parity it still holds that frame's byte; for example, 0x01 with parity 1 leaves `out_byte`=0x01 and `done`=0.
- `done` is a Moore output: high exactly when state is DONE, low in all other states.
- Reset (`rst`=0, asynchronous): state IDLE, counter 0, parity accumulator 0, `out_byte`=8'h00, `done`=0.
- Reset asserted mid-frame aborts the frame with no `done`; reception resumes on the next start bit after release.

## Timing
- Cycle S: start bit sampled. Cycles S+1 to S+8: data bits 0 to 7. Cycle S+9: parity bit. Cycle S+10: stop bit.
- `done`=1 during cycle S+11, i.e. visible right after the rising edge that samples the stop bit. It stays high for exactly one cycle.
- Minimum frame period is 11 clocks: a start bit may be sampled in the DONE cycle.
- No idle requirement between frames other than the stop bit.
- `i_data` must be stable around the rising edge; the bench drives it on the falling edge.

## Test plan
- Reset: assert `rst`=0 mid-idle -> `done`=0 and `out_byte`=0x00 immediately; line held high -> stays IDLE, `done` never asserts.
- Frame 0x55: bits 1,0,1,0,1,0,1,0, parity 1, stop 1 -> the cycle after the stop edge shows `out_byte`=0x55, `done`=1; `done`=0 the following cycle.
- Frame 0xAA: bits 0,1,0,1,0,1,0,1, parity 1, stop 1 -> `out_byte`=0xAA, `done`=1 for one cycle.
- Parity error: 0x01 (bits 1,0,0,0,0,0,0,0), parity 1, stop 1 -> `done` stays 0, `out_byte`=0x01. A following good 0x55 frame -> `done`=1.
- Framing error: 0x55, parity 1, stop 0, line held 0 for 3 more cycles, then 1 -> no `done`, no false start while low. A good frame after the line returns high is received.
- Back-to-back: a good 0x55 frame with the next start bit in its DONE cycle, then 0xAA -> two `done` pulses 11 cycles apart, with `out_byte` 0x55 then 0xAA.
